// File: rtl/radiation_sensor_pkg.sv
// radiation_sensor_pkg: command codes, error code, fsm states and response length sizing
package radiation_sensor_pkg;
  localparam logic [7:0] CMD_READ = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;
  localparam logic [7:0] CMD_READ_ALL = 8'h03;
  localparam logic [7:0] ERR_CODE = 8'hEE;
  typedef enum logic [2:0] {S_IDLE, S_RX_CMD, S_RX_ARG, S_BUILD, S_TX} state_t;
  function automatic int max_resp_len(input int n, input int b);
    return 2 + n * b;
  endfunction
endpackage

// File: rtl/event_counter.sv
// event_counter: rising-edge saturating counter with clear (clk, rst, pulse, clr -> count); clear with a coincident edge yields 1
module event_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic prev;
  logic rise;
  assign rise = pulse & ~prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      count <= '0;
    end else begin
      prev  <= pulse;
      count <= clr ? W'(rise) : (rise && !(&count)) ? count + 1'b1 : count;
    end
  end
endmodule

// File: rtl/radiation_sensor_app.sv
// radiation_sensor_app: per-channel event counting, command decode and response/replay over the byte app_rx/app_tx interface (sensor_pulse, rx_* in; tx_data/tx_data_valid out; tx_req, resend_last in)
module radiation_sensor_app
  import radiation_sensor_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] sensor_pulse,
  input  logic                    rx_soc,
  input  logic                    rx_eoc,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_valid,
  input  logic                    rx_error,
  output logic [7:0]              tx_data,
  output logic                    tx_data_valid,
  input  logic                    tx_req,
  input  logic                    resend_last
);
  localparam int W  = 8 * COUNTER_BYTES;
  localparam int NB = NUM_CHANNELS * COUNTER_BYTES;
  localparam int IW = $clog2(max_resp_len(NUM_CHANNELS, COUNTER_BYTES));
  state_t state, state_n;
  logic [7:0] cmd, ch, last_cmd, last_ch, resp_byte, snap_byte;
  logic have_ch, bad_len, last_err, have_last, cur_err, ch_bad, eoc_ok, last_byte;
  logic [IW-1:0] idx;
  logic [W-1:0] counts [NUM_CHANNELS];
  logic [7:0] snap [NB];
  logic [NUM_CHANNELS-1:0] clr;
  int resp_len, pos;
  assign ch_bad  = !have_ch || ch >= 8'(NUM_CHANNELS);
  assign cur_err = bad_len | ((cmd == CMD_READ || cmd == CMD_CLEAR) ? ch_bad :
                              cmd == CMD_READ_ALL ? have_ch : 1'b1);
  assign eoc_ok  = state == S_RX_ARG && rx_eoc && !rx_error;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign clr[c] = eoc_ok && cmd == CMD_CLEAR && !cur_err && ch == 8'(c);
    event_counter #(.W(W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .pulse (sensor_pulse[c]),
      .clr   (clr[c]),
      .count (counts[c])
    );
  end
  always_comb begin
    resp_len  = last_err ? 2 : last_cmd == CMD_READ ? 2 + COUNTER_BYTES :
                last_cmd == CMD_CLEAR ? 2 : 1 + NB;
    pos       = last_cmd == CMD_READ_ALL ? int'(idx) - 1 :
                int'(last_ch) * COUNTER_BYTES + int'(idx) - 2;
    snap_byte = '0;
    for (int i = 0; i < NB; i++) if (i == pos) snap_byte = snap[i];
    resp_byte = idx == '0 ? (last_err ? ERR_CODE : last_cmd) :
                (idx == IW'(1) && (last_err || last_cmd != CMD_READ_ALL)) ?
                (last_err ? last_cmd : last_ch) : snap_byte;
    last_byte = int'(idx) == resp_len - 1;
  end
  assign tx_data_valid = state == S_TX;
  assign tx_data       = tx_data_valid ? resp_byte : '0;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   state_n = rx_soc ? S_RX_CMD : (resend_last && have_last) ? S_TX : S_IDLE;
      S_RX_CMD: state_n = rx_soc ? S_RX_CMD : rx_eoc ? S_IDLE : rx_data_valid ? S_RX_ARG : S_RX_CMD;
      S_RX_ARG: state_n = rx_soc ? S_RX_CMD : rx_eoc ? (rx_error ? S_IDLE : S_BUILD) : S_RX_ARG;
      S_BUILD:  state_n = S_TX;
      S_TX:     state_n = rx_soc ? S_RX_CMD : (tx_req && last_byte) ? S_IDLE : S_TX;
      default:  state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd       <= '0;
      ch        <= '0;
      have_ch   <= 1'b0;
      bad_len   <= 1'b0;
      last_cmd  <= '0;
      last_ch   <= '0;
      last_err  <= 1'b0;
      have_last <= 1'b0;
      idx       <= '0;
      for (int i = 0; i < NB; i++) snap[i] <= '0;
    end else begin
      if (state == S_RX_CMD && rx_data_valid) begin
        cmd     <= rx_data;
        have_ch <= 1'b0;
        bad_len <= 1'b0;
      end
      if (state == S_RX_ARG && rx_data_valid) begin
        if (have_ch) bad_len <= 1'b1;
        else begin
          ch      <= rx_data;
          have_ch <= 1'b1;
        end
      end
      if (state == S_BUILD) begin
        for (int c = 0; c < NUM_CHANNELS; c++)
          for (int i = 0; i < COUNTER_BYTES; i++)
            snap[c*COUNTER_BYTES+i] <= counts[c][8*(COUNTER_BYTES-1-i) +: 8];
        last_cmd  <= cmd;
        last_ch   <= ch;
        last_err  <= cur_err;
        have_last <= 1'b1;
      end
      idx <= (state == S_TX && state_n == S_TX) ? idx + IW'(tx_req) : '0;
    end
  end
endmodule

// File: tb/tb_radiation_sensor_app.sv
// tb_radiation_sensor_app: directed table-driven bench for radiation_sensor_app
module tb_radiation_sensor_app;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] sensor_pulse;
  logic [1:0] sensor_pulse2;
  logic rx_soc, rx_eoc, rx_data_valid, rx_error, tx_req, resend_last;
  logic [7:0] rx_data, tx_data, tx_data2;
  logic tx_data_valid, tx_data_valid2;
  int pass_n = 0;
  int total_n = 0;
  logic [7:0] got [16];
  int got_n, stable_bad;
  typedef struct packed {
    logic [1:0]  nb;
    logic [23:0] b;
    logic        err;
    logic [3:0]  en;
    logic [79:0] e;
  } vec_t;
  vec_t vecs [13];
  radiation_sensor_app #(.NUM_CHANNELS(4), .COUNTER_BYTES(2)) u_dut (
    .clk(clk), .rst(rst), .sensor_pulse(sensor_pulse), .rx_soc(rx_soc), .rx_eoc(rx_eoc),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_error(rx_error), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_req(tx_req), .resend_last(resend_last)
  );
  radiation_sensor_app #(.NUM_CHANNELS(2), .COUNTER_BYTES(1)) u_sat (
    .clk(clk), .rst(rst), .sensor_pulse(sensor_pulse2), .rx_soc(rx_soc), .rx_eoc(rx_eoc),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_error(rx_error), .tx_data(tx_data2),
    .tx_data_valid(tx_data_valid2), .tx_req(tx_req), .resend_last(resend_last)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input int act, input int exp_v);
    total_n++;
    if (act == exp_v) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
  endtask
  function automatic logic vld(input bit s);
    return s ? tx_data_valid2 : tx_data_valid;
  endfunction
  function automatic logic [7:0] dat(input bit s);
    return s ? tx_data2 : tx_data;
  endfunction
  task automatic edges(input int c, input int n, input bit s);
    for (int k = 0; k < n; k++) begin
      if (s) sensor_pulse2[c] = 1'b1; else sensor_pulse[c] = 1'b1;
      tick;
      if (s) sensor_pulse2[c] = 1'b0; else sensor_pulse[c] = 1'b0;
      tick;
    end
  endtask
  task automatic body(input int nb, input logic [23:0] b, input logic err, input logic [3:0] ep);
    for (int i = 0; i < nb; i++) begin
      rx_data = b[23-8*i -: 8];
      rx_data_valid = 1'b1;
      tick;
      rx_data_valid = 1'b0;
    end
    rx_eoc = 1'b1;
    rx_error = err;
    sensor_pulse = sensor_pulse | ep;
    tick;
    rx_eoc = 1'b0;
    rx_error = 1'b0;
    sensor_pulse = sensor_pulse & ~ep;
  endtask
  task automatic frame(input int nb, input logic [23:0] b, input logic err, input logic [3:0] ep);
    rx_soc = 1'b1;
    tick;
    rx_soc = 1'b0;
    body(nb, b, err, ep);
  endtask
  task automatic collect(input int per, input bit s);
    int w, cyc;
    logic [7:0] held;
    bit hold;
    w = 0;
    cyc = 0;
    got_n = 0;
    stable_bad = 0;
    for (int i = 0; i < 16; i++) got[i] = 8'h5A;
    while (!vld(s) && w < 10) begin
      tick;
      w++;
    end
    while (vld(s) && cyc < 100) begin
      tx_req = (cyc % per) == 0;
      hold = !tx_req;
      held = dat(s);
      if (tx_req && got_n < 16) begin
        got[got_n] = held;
        got_n++;
      end
      tick;
      cyc++;
      if (hold && vld(s) && dat(s) != held) stable_bad++;
    end
    tx_req = 1'b0;
  endtask
  task automatic drain;
    tx_req = 1'b1;
    repeat (12) tick;
    tx_req = 1'b0;
  endtask
  task automatic expect_resp(input string nm, input int en, input logic [79:0] e);
    check({nm, " len"}, got_n, en);
    for (int i = 0; i < en; i++) check(nm, got[i], e[79-8*i -: 8]);
  endtask
  task automatic no_resp(input string nm);
    bit seen;
    seen = 1'b0;
    repeat (8) begin
      if (tx_data_valid) seen = 1'b1;
      tick;
    end
    check(nm, seen, 0);
  endtask
  initial begin
    vecs = '{
      '{2'd2, 24'h010100, 1'b0, 4'd4, {32'h01010001, 48'h0}},
      '{2'd2, 24'h010000, 1'b0, 4'd4, {32'h01000001, 48'h0}},
      '{2'd2, 24'h010200, 1'b0, 4'd4, {32'h01020005, 48'h0}},
      '{2'd2, 24'h010300, 1'b0, 4'd4, {32'h01030000, 48'h0}},
      '{2'd2, 24'h010700, 1'b0, 4'd2, {16'hEE01, 64'h0}},
      '{2'd1, 24'h090000, 1'b0, 4'd2, {16'hEE09, 64'h0}},
      '{2'd2, 24'h030000, 1'b0, 4'd2, {16'hEE03, 64'h0}},
      '{2'd3, 24'h010000, 1'b0, 4'd2, {16'hEE01, 64'h0}},
      '{2'd1, 24'h020000, 1'b0, 4'd2, {16'hEE02, 64'h0}},
      '{2'd2, 24'h010000, 1'b1, 4'd0, 80'h0},
      '{2'd0, 24'h000000, 1'b0, 4'd0, 80'h0},
      '{2'd2, 24'h020000, 1'b1, 4'd0, 80'h0},
      '{2'd2, 24'h010000, 1'b0, 4'd4, {32'h01000001, 48'h0}}
    };
    sensor_pulse = '0;
    sensor_pulse2 = '0;
    {rx_soc, rx_eoc, rx_data_valid, rx_error, tx_req, resend_last} = '0;
    rx_data = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("reset tx_data", tx_data, 0);
    check("reset tx_data_valid", tx_data_valid, 0);
    resend_last = 1'b1;
    tick;
    resend_last = 1'b0;
    no_resp("resend without last");
    edges(2, 5, 1'b0);
    frame(2, 24'h010200, 1'b0, 4'b0);
    check("valid 1 cycle after eoc", tx_data_valid, 0);
    tick;
    check("valid 2 cycles after eoc", tx_data_valid, 1);
    collect(1, 1'b0);
    expect_resp("read ch2", 4, {32'h01020005, 48'h0});
    drain;
    sensor_pulse[0] = 1'b1;
    repeat (100) tick;
    sensor_pulse[0] = 1'b0;
    tick;
    frame(2, 24'h010000, 1'b0, 4'b0);
    collect(1, 1'b0);
    expect_resp("held pulse ch0", 4, {32'h01000001, 48'h0});
    drain;
    edges(1, 260, 1'b1);
    frame(2, 24'h010100, 1'b0, 4'b0);
    collect(1, 1'b1);
    expect_resp("saturate ch1", 3, {24'h0101FF, 56'h0});
    drain;
    edges(1, 3, 1'b0);
    frame(2, 24'h020100, 1'b0, 4'b0010);
    collect(1, 1'b0);
    expect_resp("clear ch1", 2, {16'h0201, 64'h0});
    drain;
    for (int v = 0; v < 13; v++) begin
      frame(int'(vecs[v].nb), vecs[v].b, vecs[v].err, 4'b0);
      if (vecs[v].en == 4'd0) no_resp($sformatf("vec%0d no response", v));
      else begin
        collect(1, 1'b0);
        expect_resp($sformatf("vec%0d", v), int'(vecs[v].en), vecs[v].e);
        drain;
      end
    end
    frame(2, 24'h020200, 1'b0, 4'b0);
    collect(1, 1'b0);
    expect_resp("clear ch2", 2, {16'h0202, 64'h0});
    drain;
    edges(1, 1, 1'b0);
    edges(2, 3, 1'b0);
    edges(3, 4, 1'b0);
    frame(1, 24'h030000, 1'b0, 4'b0);
    collect(1, 1'b0);
    expect_resp("read_all", 9, {72'h030001000200030004, 8'h0});
    drain;
    edges(0, 3, 1'b0);
    resend_last = 1'b1;
    tick;
    resend_last = 1'b0;
    collect(1, 1'b0);
    expect_resp("resend", 9, {72'h030001000200030004, 8'h0});
    drain;
    frame(1, 24'h030000, 1'b0, 4'b0);
    collect(3, 1'b0);
    expect_resp("slow req", 9, {72'h030004000200030004, 8'h0});
    check("tx_data hold stable", stable_bad, 0);
    drain;
    frame(1, 24'h030000, 1'b0, 4'b0);
    tick;
    check("abort pre valid", tx_data_valid, 1);
    tx_req = 1'b1;
    repeat (2) tick;
    tx_req = 1'b0;
    rx_soc = 1'b1;
    tick;
    rx_soc = 1'b0;
    check("abort valid drop", tx_data_valid, 0);
    body(2, 24'h010200, 1'b0, 4'b0);
    collect(1, 1'b0);
    expect_resp("after abort", 4, {32'h01020003, 48'h0});
    drain;
    frame(1, 24'h030000, 1'b0, 4'b0);
    tick;
    check("rst pre valid", tx_data_valid, 1);
    rst = 1'b1;
    tick;
    check("rst tx_data", tx_data, 0);
    check("rst tx_data_valid", tx_data_valid, 0);
    rst = 1'b0;
    tick;
    resend_last = 1'b1;
    tick;
    resend_last = 1'b0;
    no_resp("resend after rst");
    frame(2, 24'h010200, 1'b0, 4'b0);
    collect(1, 1'b0);
    expect_resp("read after rst", 4, {32'h01020000, 48'h0});
    drain;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/radiation_sensor_app.md
Name: radiation_sensor_app

Overview:
- Byte-wide application layer between the iso14443a core's app_rx/app_tx byte interfaces and NUM_CHANNELS radiation-event pulse inputs.
- Counts events per channel in saturating counters. Decodes PCD command frames and builds response frames.
- Replays the last response byte-for-byte when the core requests a resend.
- Generalised successor of the current sensor top, which ties app_tx data_valid low. This block adds per-channel counting, command decode and response generation.

Parameters:
- NUM_CHANNELS, 4, number of sensor pulse inputs (1..16).
- COUNTER_BYTES, 2, counter width in bytes (1..4); counters are 8*COUNTER_BYTES bits.

Ports:
- clk  in  1  13.56MHz recovered carrier clock.
- rst  in  1  synchronous, active-high reset.
- sensor_pulse  in  NUM_CHANNELS  event inputs, already synchronised to clk; a rising edge counts one event.
- rx_soc  in  1  start of received frame (1-cycle pulse).
- rx_eoc  in  1  end of received frame (1-cycle pulse).
- rx_data  in  8  received byte.
- rx_data_valid  in  1  rx_data is valid this cycle.
- rx_error  in  1  frame error; sticky until the next rx_soc.
- tx_data  out  8  response byte.
- tx_data_valid  out  1  tx_data is valid.
- tx_req  in  1  core consumes tx_data this cycle.
- resend_last  in  1  1-cycle pulse requesting replay of the last response.

Behaviour:
- Reset: tx_data=0, tx_data_valid=0, all counters=0, snapshot=0, FSM=IDLE, have_last=0.
- Counting:
  - Per-channel rising-edge detect on sensor_pulse; at most one event per channel per cycle.
  - Counter saturates at all-ones and never wraps.
  - CLEAR of a channel in the same cycle as an edge on it: counter becomes 1 (event not lost).
- Command set (codes held in the package):
  - READ=0x01, frame {0x01, ch}, response {0x01, ch, count MSB first}.
  - CLEAR=0x02, frame {0x02, ch}, response {0x02, ch}; clear takes effect on the eoc cycle.
  - READ_ALL=0x03, frame {0x03}, response {0x03, count[0]..count[N-1]}, each count MSB first.
  - Unknown code, wrong length, or ch>=NUM_CHANNELS: response {0xEE, first byte}.
- FSM states and transitions:
  - IDLE: rx_soc -> RX_CMD.
  - RX_CMD: valid byte latched as cmd -> RX_ARG.
  - RX_ARG: next valid byte latched as ch; any further byte sets a bad_len flag.
  - On rx_eoc -> BUILD.
  - rx_error set at eoc, or eoc with zero bytes -> IDLE with no response and no counter change.
  - BUILD (1 cycle): all counts latched into the snapshot, so READ_ALL is atomic. cmd, ch and error status stored as the "last response"; have_last=1 -> TX.
  - TX: tx_data_valid rises 2 cycles after rx_eoc.
- TX handshake:
  - tx_data is held stable while tx_data_valid=1.
  - A byte advances only on tx_req&tx_data_valid; the next byte is presented in the following cycle.
  - After the final byte is accepted, tx_data_valid drops the next cycle -> IDLE.
- rx_soc while in TX: abort the response (tx_data_valid=0 next cycle), go to RX_CMD; the last response is retained.
- resend_last in IDLE with have_last=1: replay the stored response from the snapshot, not live counters, so the replay is identical. Ignored when have_last=0 or when not in IDLE.
- Byte index counter sized for 2+NUM_CHANNELS*COUNTER_BYTES.
- rst mid-frame or mid-TX: immediate return to reset state; next frame is processed normally.

Decomposition:
- radiation_sensor_pkg: command codes, ERR_CODE=0xEE, FSM state enum, and the max response length function.
- Sub-module event_counter (edge detect, saturating count, clear-with-event rule, one instance per channel), instantiated by generate.

Test Plan:
- 5 edges on ch2 (N=4, 2 bytes), frame {0x01,0x02}, tx_req always 1 -> bytes 01 02 00 05; valid rises 2 cycles after eoc.
- Pulse held high 100 cycles on ch0 -> count 1. Then 0x10000 edges on ch1 (COUNTER_BYTES=2) -> READ returns FF FF.
- Frame {0x02,0x01} with an edge on ch1 in the eoc cycle -> response 02 01; subsequent READ ch1 returns 00 01.
- Frames {0x01,0x07}, {0x09} and {0x03,0x00} -> responses EE 01, EE 09, EE 03. {0x01,0x00} with rx_error -> no tx_data_valid.
- READ_ALL with counts 1,2,3,4, then 3 edges on ch0, then resend_last -> both responses are 03 00 01 00 02 00 03 00 04.
- tx_req toggled every 3rd cycle -> tx_data stable between accepts. rx_soc mid-TX -> valid drops next cycle. rst mid-TX -> all outputs 0 next cycle.
